// File: rtl/sr_pkg.sv
// Shared definitions for the SR bank controller: FSM state encoding,
// {s,r} command codes and the index-width helper.
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        ACK   = 2'd2
    } state_e;

    // Command codes, ordered {s,r}.
    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_RST  = 2'b01;
    localparam logic [1:0] CMD_SET  = 2'b10;
    localparam logic [1:0] CMD_ILL  = 2'b11;

    // Bits needed to index n items; never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sr_rr_arb.sv
// Combinational round-robin picker: scans last+1, last+2, ... modulo NREQ
// and returns the first requester found as one-hot plus binary index.
module sr_rr_arb
    import sr_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int LW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [LW-1:0]   last_i,
    output logic [NREQ-1:0] win_oh_o,
    output logic [LW-1:0]   win_idx_o,
    output logic            valid_o
);

    int unsigned cand;

    // Pick the first pending requester after the previous winner.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
        win_oh_o  = '0;
        win_idx_o = '0;
        valid_o   = 1'b0;
        cand      = 0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(last_i) + i) % NREQ;
            if (!valid_o && req_i[cand]) begin
                valid_o         = 1'b1;
                win_oh_o[cand]  = 1'b1;
                win_idx_o       = LW'(cand);
            end
        end
    end

endmodule

// File: rtl/sr_bank_ctrl.sv
// Shares one bank of SR cells between NREQ requesters. One command is
// arbitrated, applied and acknowledged every three cycles
// (IDLE -> APPLY -> ACK); the illegal s=r=1 code and out-of-range indices
// leave the bank untouched and are acknowledged with err.
module sr_bank_ctrl
    import sr_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int NFF  = 8,
    localparam int IDXW = idx_width(NFF)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      cmd_s,
    input  logic [NREQ-1:0]      cmd_r,
    input  logic [NREQ*IDXW-1:0] cmd_idx,
    output logic [NREQ-1:0]      gnt,
    output logic                 done,
    output logic                 err,
    output logic                 busy,
    output logic [NFF-1:0]       q,
    output logic [NFF-1:0]       qbar
);

    localparam int              LW       = idx_width(NREQ);
    localparam logic [LW-1:0]   LAST_RST = LW'(NREQ - 1);
    localparam logic [IDXW:0]   NFF_LIM  = (IDXW + 1)'(NFF);

    state_e            state_q, state_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [NREQ-1:0]   win_oh_q, win_oh_d;
    logic [LW-1:0]     win_idx_q, win_idx_d;
    logic [LW-1:0]     last_q, last_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [NFF-1:0]    bank_q, bank_d;

    logic [NREQ-1:0]   arb_oh;
    logic [LW-1:0]     arb_idx;
    logic              arb_valid;
    logic              idx_oob;
    logic              cmd_err;

    sr_rr_arb #(.NREQ(NREQ)) u_arb (
        .req_i     (req),
        .last_i    (last_q),
        .win_oh_o  (arb_oh),
        .win_idx_o (arb_idx),
        .valid_o   (arb_valid)
    );

    // An out-of-range index overrides the {s,r} decode.
    assign idx_oob = ({1'b0, idx_q} >= NFF_LIM);
    assign cmd_err = idx_oob || (cmd_q == CMD_ILL);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic: a fixed three-cycle walk once a request is seen.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_valid) state_d = APPLY;
            APPLY:   state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath logic: latch the winner, update one cell, acknowledge.
    always_comb begin
        cmd_d     = cmd_q;
        idx_d     = idx_q;
        win_oh_d  = win_oh_q;
        win_idx_d = win_idx_q;
        last_d    = last_q;
        bank_d    = bank_q;
        gnt_d     = '0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        busy_d    = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    cmd_d     = {cmd_s[arb_idx], cmd_r[arb_idx]};
                    idx_d     = cmd_idx[arb_idx*IDXW +: IDXW];
                    win_oh_d  = arb_oh;
                    win_idx_d = arb_idx;
                end
            end
            APPLY: begin
                if (!idx_oob) begin
                    case (cmd_q)
                        CMD_SET: bank_d[idx_q] = 1'b1;
                        CMD_RST: bank_d[idx_q] = 1'b0;
                        default: ;
                    endcase
                end
                gnt_d  = win_oh_q;
                done_d = 1'b1;
                err_d  = cmd_err;
            end
            ACK:     last_d = win_idx_q;
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q     <= CMD_HOLD;
            idx_q     <= '0;
            win_oh_q  <= '0;
            win_idx_q <= '0;
            last_q    <= LAST_RST;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            // NOTE: the cell bank is reset too, since its all-zero reset value is visible on q.
            bank_q    <= '0;
        end else begin
            cmd_q     <= cmd_d;
            idx_q     <= idx_d;
            win_oh_q  <= win_oh_d;
            win_idx_q <= win_idx_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            bank_q    <= bank_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign err  = err_q;
    assign busy = busy_q;
    assign q    = bank_q;
    assign qbar = ~bank_q;

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// Scoreboard bench for sr_bank_ctrl: an 8-cell instance for the main
// scenarios and a 6-cell instance for out-of-range indices.
module tb_sr_bank_ctrl;

    typedef struct packed {
        logic [3:0] gnt;
        logic       err;
        logic [7:0] q;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, cmd_s, cmd_r;
    logic [11:0] cmd_idx;
    logic [3:0]  gnt;
    logic        done, err, busy;
    logic [7:0]  q, qbar;

    logic [3:0]  req6, cmd_s6, cmd_r6;
    logic [11:0] cmd_idx6;
    logic [3:0]  gnt6;
    logic        done6, err6, busy6;
    logic [5:0]  q6, qbar6;

    exp_t       sb[$];
    logic [7:0] model_q;
    logic [7:0] model_q6;
    int         n_pass;
    int         n_total;

    always #5 clk = ~clk;

    sr_bank_ctrl #(.NREQ(4), .NFF(8)) u_dut (
        .clk(clk), .rst(rst), .req(req), .cmd_s(cmd_s), .cmd_r(cmd_r),
        .cmd_idx(cmd_idx), .gnt(gnt), .done(done), .err(err), .busy(busy),
        .q(q), .qbar(qbar)
    );

    sr_bank_ctrl #(.NREQ(4), .NFF(6)) u_dut6 (
        .clk(clk), .rst(rst), .req(req6), .cmd_s(cmd_s6), .cmd_r(cmd_r6),
        .cmd_idx(cmd_idx6), .gnt(gnt6), .done(done6), .err(err6), .busy(busy6),
        .q(q6), .qbar(qbar6)
    );

    // Reference behaviour of one command against a bank of nff cells.
    function automatic exp_t model(input logic [3:0] g, input logic s, input logic r,
                                   input int idx, input int nff, input logic [7:0] qin);
        exp_t e;
        e.gnt = g;
        e.err = 1'b0;
        e.q   = qin;
        if (idx >= nff)  e.err = 1'b1;
        else if (s && r) e.err = 1'b1;
        else if (s)      e.q[idx] = 1'b1;
        else if (r)      e.q[idx] = 1'b0;
        return e;
    endfunction

    // Post a command on requester k and queue its expected acknowledge.
    task automatic post(input bit sel6, input int k, input logic s, input logic r,
                        input logic [2:0] idx);
        if (sel6) begin
            cmd_s6[k] = s; cmd_r6[k] = r; cmd_idx6[k*3 +: 3] = idx; req6[k] = 1'b1;
        end else begin
            cmd_s[k] = s; cmd_r[k] = r; cmd_idx[k*3 +: 3] = idx; req[k] = 1'b1;
        end
    endtask

    task automatic expect_cmd(input bit sel6, input int k, input logic s, input logic r,
                              input int idx);
        exp_t e;
        logic [3:0] g;
        g = 4'b0001 << k;
        if (sel6) begin
            e = model(g, s, r, idx, 6, model_q6);
            model_q6 = e.q;
        end else begin
            e = model(g, s, r, idx, 8, model_q);
            model_q = e.q;
        end
        sb.push_back(e);
    endtask

    // Watch the DUT until every queued acknowledge has been seen or the budget runs out.
    task automatic drain(input bit sel6, input bit keep, input int budget);
        int   cyc      = 0;
        int   idle_run = 0;
        bit   seen     = 0;
        exp_t e;
        logic [3:0] g;
        logic d, er, b;
        logic [7:0] oq, oqb;
        while (sb.size() > 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (sel6) begin
                g = gnt6; d = done6; er = err6; b = busy6; oq = {2'b00, q6}; oqb = {2'b11, qbar6};
            end else begin
                g = gnt; d = done; er = err; b = busy; oq = q; oqb = qbar;
            end
            if (d === 1'b1) begin
                e = sb.pop_front();
                n_total++; if (g !== e.gnt) $display("FAIL ack_gnt: got %b want %b", g, e.gnt); else n_pass++;
                n_total++; if (er !== e.err) $display("FAIL ack_err: got %b want %b", er, e.err); else n_pass++;
                n_total++; if (oq !== e.q) $display("FAIL ack_q: got %h want %h", oq, e.q); else n_pass++;
                n_total++; if (oqb !== ~e.q) $display("FAIL ack_qbar: got %h want %h", oqb, ~e.q); else n_pass++;
                if (keep && seen) begin
                    n_total++;
                    if (idle_run !== 1) $display("FAIL idle_gap: got %0d want 1", idle_run); else n_pass++;
                end
                seen     = 1;
                idle_run = 0;
                if (sel6) begin
                    if (!keep) req6 = req6 & ~g; else if (sb.size() == 0) req6 = '0;
                end else begin
                    if (!keep) req = req & ~g; else if (sb.size() == 0) req = '0;
                end
            end else begin
                n_total++;
                if (g !== 4'b0000 || er !== 1'b0) $display("FAIL quiet_ack: got gnt=%b err=%b want 0000/0", g, er);
                else n_pass++;
                if (b === 1'b0) idle_run++;
            end
        end
        n_total++;
        if (sb.size() != 0) begin
            $display("FAIL ack_timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = '0; cmd_s = '0; cmd_r = '0; cmd_idx = '0;
        req6 = '0; cmd_s6 = '0; cmd_r6 = '0; cmd_idx6 = '0;
        model_q = '0; model_q6 = '0;
        repeat (2) @(negedge clk);
        n_total++; if (q !== 8'h00) $display("FAIL reset_q: got %h want 00", q); else n_pass++;
        n_total++; if (qbar !== 8'hFF) $display("FAIL reset_qbar: got %h want ff", qbar); else n_pass++;
        n_total++; if ({gnt, done, err, busy} !== 7'b0) $display("FAIL reset_ctl: got %b want 0000000", {gnt, done, err, busy}); else n_pass++;
        n_total++; if (qbar6 !== 6'h3F) $display("FAIL reset_qbar6: got %h want 3f", qbar6); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_set();
        post(0, 0, 1'b1, 1'b0, 3'd3);
        expect_cmd(0, 0, 1'b1, 1'b0, 3);
        drain(0, 0, 20);
    endtask

    task automatic test_arbitration();
        // A hold from requester 3 leaves q alone and moves the pointer to 3.
        post(0, 3, 1'b0, 1'b0, 3'd1);
        expect_cmd(0, 3, 1'b0, 1'b0, 1);
        drain(0, 0, 20);
        post(0, 0, 1'b0, 1'b1, 3'd3);
        post(0, 2, 1'b1, 1'b0, 3'd5);
        expect_cmd(0, 0, 1'b0, 1'b1, 3);
        expect_cmd(0, 2, 1'b1, 1'b0, 5);
        drain(0, 0, 40);
    endtask

    task automatic test_illegal();
        post(0, 1, 1'b1, 1'b1, 3'd5);
        expect_cmd(0, 1, 1'b1, 1'b1, 5);
        drain(0, 0, 20);
    endtask

    task automatic test_idx_range();
        post(1, 3, 1'b1, 1'b0, 3'd7);
        expect_cmd(1, 3, 1'b1, 1'b0, 7);
        drain(1, 0, 20);
        post(1, 3, 1'b1, 1'b0, 3'd5);
        expect_cmd(1, 3, 1'b1, 1'b0, 5);
        drain(1, 0, 20);
        post(1, 3, 1'b0, 1'b1, 3'd6);
        expect_cmd(1, 3, 1'b0, 1'b1, 6);
        drain(1, 0, 20);
    endtask

    task automatic test_back_to_back();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_q = '0;
        post(0, 0, 1'b1, 1'b0, 3'd0);
        post(0, 1, 1'b1, 1'b0, 3'd7);
        post(0, 2, 1'b0, 1'b1, 3'd0);
        post(0, 3, 1'b1, 1'b0, 3'd4);
        for (int n = 0; n < 2; n++) begin
            expect_cmd(0, 0, 1'b1, 1'b0, 0);
            expect_cmd(0, 1, 1'b1, 1'b0, 7);
            expect_cmd(0, 2, 1'b0, 1'b1, 0);
            expect_cmd(0, 3, 1'b1, 1'b0, 4);
        end
        drain(0, 1, 60);
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        post(0, 0, 1'b1, 1'b0, 3'd2);
        @(negedge clk);
        n_total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL apply_state: got busy=%b done=%b want 1/0", busy, done); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (q !== 8'h00) $display("FAIL abort_q: got %h want 00", q); else n_pass++;
        n_total++; if (gnt !== 4'b0000) $display("FAIL abort_gnt: got %b want 0000", gnt); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
        repeat (2) @(negedge clk);
        n_total++; if (done !== 1'b0) $display("FAIL abort_done: got %b want 0", done); else n_pass++;
        rst = 1'b1;
        model_q = '0;
        expect_cmd(0, 0, 1'b1, 1'b0, 2);
        drain(0, 0, 20);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_single_set();
        test_arbitration();
        test_illegal();
        test_idx_range();
        test_back_to_back();
        test_reset_abort();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
